// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer: debounced start key, per-layer start/done sequencing with timeout, result bytes to the UART.
module mnist_infer_sequencer #(
    parameter int N_LAYERS        = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 4_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_0,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    input  logic [3:0]          result_class,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                led_0,
    output logic                led_1
);
    localparam int IW = N_LAYERS > 1 ? $clog2(N_LAYERS) : 1;
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, START, WAIT, SEND0, SEND1, ERR0, ERR1} state_t;
    state_t state, state_n;

    logic          key_s1, key_s2, key_db;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] to_cnt;
    logic [IW-1:0] idx;
    logic [3:0]    cls;
    logic          go, db_end, done, last, tmo;

    assign db_end = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign go     = key_db && !key_s2 && db_end;
    // the first WAIT cycle coincides with the visible start pulse, so done is only taken once to_cnt has moved
    assign done   = layer_done[idx] && to_cnt != '0;
    assign last   = idx == IW'(N_LAYERS - 1);
    assign tmo    = to_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key_0;
            key_s2 <= key_s1;
            if (key_s2 == key_db)
                db_cnt <= '0;
            else if (db_end) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = done ? (last ? SEND0 : START) : tmo ? ERR0 : WAIT;
            SEND0:   state_n = tx_ready ? SEND1 : SEND0;
            SEND1:   state_n = tx_ready ? IDLE : SEND1;
            ERR0:    state_n = tx_ready ? ERR1 : ERR0;
            ERR1:    state_n = tx_ready ? IDLE : ERR1;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = state inside {SEND0, SEND1, ERR0, ERR1};
        led_0    = state != IDLE;
        tx_data  = state == SEND0 ? (cls > 4'd9 ? 8'h45 : 8'h30 + {4'd0, cls}) :
                   state == ERR0  ? 8'h54 : tx_valid ? 8'h0A : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_start <= '0;
            to_cnt      <= '0;
            idx         <= '0;
            cls         <= '0;
            led_1       <= 1'b0;
        end else begin
            layer_start <= state == START ? N_LAYERS'(1) << idx : '0;
            to_cnt      <= state == START ? '0 : (state == WAIT && !tmo) ? to_cnt + TW'(1) : to_cnt;
            if (state == IDLE && go)
                idx <= '0;
            else if (state == WAIT && done && !last)
                idx <= idx + IW'(1);
            if (state == WAIT && done && last)
                cls <= result_class;
            if (state == IDLE && go)
                led_1 <= 1'b0;
            else if ((state == WAIT && !done && tmo) || (state == SEND0 && cls > 4'd9))
                led_1 <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// tb_mnist_infer_sequencer: table-driven runs plus timed sequences for latency, timeout and reset.
module tb_mnist_infer_sequencer;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst, key_0, tx_ready, tx_valid, led_0, led_1;
    logic [N-1:0] layer_start, layer_done, mute;
    logic [3:0]   result_class;
    logic [7:0]   tx_data;

    int checks = 0, errors = 0, cyc = 0;
    int cd[N];
    int pl[$];
    int got[$];

    typedef struct {
        int           lo;
        int           cls;
        logic [N-1:0] m;
        int           dly;
        int           np;
        int           b0;
        int           b1;
        int           l1;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    mnist_infer_sequencer #(
        .N_LAYERS(N),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_0(key_0),
        .layer_start(layer_start),
        .layer_done(layer_done),
        .result_class(result_class),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .led_0(led_0),
        .led_1(led_1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: log transfers, check held bytes, log pulses, and answer each start 10 cycles later
    task automatic tick();
        logic       hold;
        logic [7:0] hd;
        if (tx_valid && tx_ready) got.push_back(int'(tx_data));
        hold = tx_valid && !tx_ready;
        hd   = tx_data;
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            chk("hold_valid", int'(tx_valid), 1);
            chk("hold_data", int'(tx_data), int'(hd));
        end
        for (int i = 0; i < N; i++) begin
            if (layer_start[i]) pl.push_back(i);
            layer_done[i] = 1'b0;
            if (cd[i] > 0) begin
                cd[i]--;
                layer_done[i] = cd[i] == 0;
            end
            if (layer_start[i] && !mute[i]) cd[i] = 10;
        end
    endtask

    task automatic run_vec(input vec_t v, input int t);
        int hc = 0;
        int ord = 0;
        result_class = 4'(v.cls);
        mute = v.m;
        tx_ready = v.dly == 0;
        pl.delete();
        got.delete();
        key_0 = 1'b0;
        repeat (v.lo) tick();
        key_0 = 1'b1;
        repeat (160) begin
            tick();
            if (tx_valid) begin
                if (hc < v.dly) hc++;
                else tx_ready = 1'b1;
            end
        end
        for (int i = 0; i < pl.size(); i++) if (pl[i] != i) ord++;
        chk($sformatf("v%0d pulse_count", t), pl.size(), v.np);
        chk($sformatf("v%0d pulse_order", t), ord, 0);
        chk($sformatf("v%0d byte_count", t), got.size(), v.b0 < 0 ? 0 : 2);
        chk($sformatf("v%0d byte0", t), got.size() > 0 ? got[0] : -1, v.b0);
        chk($sformatf("v%0d byte1", t), got.size() > 1 ? got[1] : -1, v.b1);
        chk($sformatf("v%0d led_0", t), int'(led_0), 0);
        chk($sformatf("v%0d led_1", t), int'(led_1), v.l1);
        tx_ready = 1'b1;
        mute = '0;
    endtask

    initial begin
        tbl[0] = '{1, 7, 5'b00000, 0, 0, -1, -1, 0};
        tbl[1] = '{3, 7, 5'b00000, 0, 0, -1, -1, 0};
        tbl[2] = '{4, 7, 5'b00000, 0, 5, 8'h37, 8'h0A, 0};
        tbl[3] = '{10, 12, 5'b00000, 5, 5, 8'h45, 8'h0A, 1};
        tbl[4] = '{10, 9, 5'b00000, 0, 5, 8'h39, 8'h0A, 0};
        tbl[5] = '{10, 10, 5'b00000, 0, 5, 8'h45, 8'h0A, 1};
        tbl[6] = '{10, 0, 5'b00100, 0, 3, 8'h54, 8'h0A, 1};
        tbl[7] = '{2, 0, 5'b00000, 0, 0, -1, -1, 1};
        tbl[8] = '{10, 0, 5'b00000, 0, 5, 8'h30, 8'h0A, 0};
        tbl[9] = '{10, 15, 5'b10000, 3, 5, 8'h54, 8'h0A, 1};

        for (int i = 0; i < N; i++) cd[i] = 0;
        rst = 1'b1;
        key_0 = 1'b1;
        tx_ready = 1'b1;
        result_class = '0;
        layer_done = '0;
        mute = '0;
        repeat (3) tick();
        chk("rst layer_start", int'(layer_start), 0);
        chk("rst tx_valid", int'(tx_valid), 0);
        chk("rst tx_data", int'(tx_data), 0);
        chk("rst led_0", int'(led_0), 0);
        chk("rst led_1", int'(led_1), 0);
        rst = 1'b0;
        repeat (5) tick();

        for (int t = 0; t < 10; t++) run_vec(tbl[t], t);

        // latency, coincident/foreign done pulses and a second press while busy
        result_class = 4'd7;
        pl.delete();
        got.delete();
        key_0 = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k == 10 || k == 35) key_0 = 1'b1;
            if (k == 25) key_0 = 1'b0;
            if (k == 5) chk("A led_0 before go", int'(led_0), 0);
            if (k == 6) begin
                chk("A led_0 rise", int'(led_0), 1);
                chk("A no pulse in START", int'(layer_start), 0);
            end
            if (k == 7) chk("A start0 pulse", int'(layer_start), 1);
            if (k == 8) chk("A start0 one cycle", int'(layer_start), 0);
            if (k == 19) begin
                chk("A start1 pulse", int'(layer_start), 2);
                layer_done[1] = 1'b1;
            end
            if (k == 20) layer_done[4] = 1'b1;
            if (k == 21) chk("A coincident done ignored", int'(layer_start), 0);
            if (k == 31) chk("A start2 pulse", int'(layer_start), 4);
            if (k == 55) chk("A start4 pulse", int'(layer_start), 16);
            if (k == 65) chk("A no valid before done", int'(tx_valid), 0);
            if (k == 66) begin
                chk("A valid after done", int'(tx_valid), 1);
                chk("A byte0", int'(tx_data), 8'h37);
            end
            if (k == 67) begin
                chk("A byte1", int'(tx_data), 8'h0A);
                chk("A led_0 busy", int'(led_0), 1);
            end
            if (k == 68) begin
                chk("A idle valid", int'(tx_valid), 0);
                chk("A idle led_0", int'(led_0), 0);
            end
        end
        chk("A pulse count", pl.size(), 5);
        chk("A byte count", got.size(), 2);
        chk("A led_1", int'(led_1), 0);

        // timeout on layer 2, exact error entry
        mute = 5'b00100;
        pl.delete();
        got.delete();
        key_0 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 10) key_0 = 1'b1;
            if (k == 31) chk("B start2 pulse", int'(layer_start), 4);
            if (k == 80) begin
                chk("B no err yet", int'(tx_valid), 0);
                chk("B led_1 before", int'(led_1), 0);
            end
            if (k == 81) begin
                chk("B err valid", int'(tx_valid), 1);
                chk("B err byte0", int'(tx_data), 8'h54);
                chk("B led_1 set", int'(led_1), 1);
            end
            if (k == 82) chk("B err byte1", int'(tx_data), 8'h0A);
            if (k == 83) chk("B idle led_0", int'(led_0), 0);
        end
        chk("B pulse count", pl.size(), 3);
        chk("B byte count", got.size(), 2);
        chk("B led_1 sticky", int'(led_1), 1);
        mute = '0;

        // reset during WAIT on layer 3
        pl.delete();
        got.delete();
        key_0 = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (k == 10) key_0 = 1'b1;
            if (k == 5) chk("C led_1 held until go", int'(led_1), 1);
            if (k == 6) chk("C led_1 cleared", int'(led_1), 0);
            if (k == 43) chk("C start3 pulse", int'(layer_start), 8);
            if (k == 46) rst = 1'b1;
            if (k == 47) begin
                rst = 1'b0;
                chk("C rst led_0", int'(led_0), 0);
                chk("C rst tx_valid", int'(tx_valid), 0);
                chk("C rst layer_start", int'(layer_start), 0);
                chk("C pulses before rst", pl.size(), 4);
            end
        end
        chk("C no later pulses", pl.size(), 4);
        chk("C no bytes", got.size(), 0);
        chk("C led_0 idle", int'(led_0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mnist_infer_sequencer.md
# mnist_infer_sequencer

Top-level control sequencer for the MNIST inference pipeline. It debounces the start button, runs the layer engines (conv/pool/fc) one at a time through per-layer start/done handshakes, and guards each layer with a timeout. It then reports the classified digit, or an error code, as two bytes on a valid/ready byte stream feeding the UART transmitter. It also drives the two status LEDs.

## Interface
- `N_LAYERS`, default 5: number of layer engines run in order, index 0 first.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable-low cycles needed to accept a key press (20 ms at 50 MHz).
- `TIMEOUT_CYCLES`, default 4_000_000: maximum cycles allowed between a layer start and its done.
- `clk`, input, 1: system clock. One clock domain.
- `rst`, input, 1: synchronous reset, active-high.
- `key_0`, input, 1: raw push button, active-low, asynchronous to `clk`.
- `layer_start`, output, `N_LAYERS`: one-cycle start pulse per layer.
- `layer_done`, input, `N_LAYERS`: one-cycle done pulse per layer.
- `result_class`, input, 4: class index from the final layer; valid in the cycle `layer_done[N_LAYERS-1]` is high.
- `tx_valid`, output, 1: byte available to the UART.
- `tx_data`, output, 8: byte to transmit.
- `tx_ready`, input, 1: UART accepts the byte.
- `led_0`, output, 1: busy indicator; high in every state except IDLE.
- `led_1`, output, 1: sticky error indicator.

## Operation
- **Key path**
  - 2-FF synchronizer on `key_0`, then a debounce counter.
  - The counter is cleared whenever the synchronized level differs from the debounced level.
  - The debounced level flips when the counter reaches `DEBOUNCE_CYCLES-1`.
  - A debounced high-to-low transition raises `go` for one cycle.
  - `go` is ignored outside IDLE. It is not queued.
- **FSM states:** IDLE, START, WAIT, SEND0, SEND1, ERR0, ERR1.
- **IDLE**
  - On `go`: layer index `idx`←0, clear `led_1`, go to START.
- **START**
  - Drive `layer_start[idx]`=1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT** (the timeout counter increments each cycle)
  - `layer_done[idx]`=1 and `idx`<`N_LAYERS`-1: `idx`++, go to START.
  - `layer_done[idx]`=1 and `idx`=`N_LAYERS`-1: latch `result_class`, go to SEND0.
  - Timeout counter reaches `TIMEOUT_CYCLES`-1 without done: go to ERR0, set `led_1`.
  - Done and timeout in the same cycle: done wins.
  - `layer_done` bits other than `idx` are ignored in every state.
- **SEND0 / SEND1**
  - SEND0 sends the first byte:
    - latched class ≤ 9: 0x30+class;
    - latched class > 9: 'E' (0x45), and `led_1` is set.
  - SEND1 sends 0x0A.
  - Each state advances on `tx_valid`&&`tx_ready`.
  - After SEND1 completes, return to IDLE.
- **ERR0 / ERR1**
  - ERR0 sends 'T' (0x54), ERR1 sends 0x0A, then IDLE.
  - `led_1` stays set.
- **Handshake**
  - `tx_valid` is high in SEND*/ERR* only.
  - `tx_data` is stable while `tx_valid`&&!`tx_ready`.
  - `tx_valid` never drops without a transfer.
- **Width rules**
  - `idx` is `$clog2(N_LAYERS)` bits (minimum 1).
  - Counters are sized by `$clog2` of their parameter. No wrap is possible because each counter stops or clears at its terminal value.
- **Reset**
  - `rst` mid-operation aborts immediately to IDLE with no completion byte.
  - `led_1` is cleared.

## Timing
- **Reset values**
  - `layer_start`=0, `tx_valid`=0, `tx_data`=0x00, `led_0`=0, `led_1`=0.
  - Debounced key=1, counters=0, state IDLE.
- **Key latency**
  - The key must be low at the synchronizer output for `DEBOUNCE_CYCLES` consecutive cycles.
  - Then: `go` fires, +1 cycle to START, +1 to the visible `layer_start[0]` pulse.
- **Layer timing**
  - Done-to-next-start latency is 2 cycles: WAIT→START, then pulse.
  - A done pulse coincident with the start-pulse cycle is not sampled. The earliest accepted done is one cycle after the start pulse.
- **UART timing**
  - Final done to `tx_valid` high: 1 cycle.
  - With `tx_ready` tied high, the two bytes transfer on consecutive cycles. IDLE is reached the cycle after the second transfer.
- **LED timing**
  - `led_0` rises the cycle after `go` and falls on IDLE entry.

## Test plan
- **Normal run.** Setup: DEBOUNCE_CYCLES=4, N_LAYERS=5, each layer engine modelled to answer done 10 cycles after its start, `result_class`=7, `tx_ready`=1. Stimulus: hold `key_0` low for 10 cycles. Required:
  - `layer_start` pulses 0→4 in order, one pulse each;
  - bytes 0x37 then 0x0A;
  - `led_0` high throughout, `led_1`=0.
- **Glitch rejection.** Stimulus: a 1-cycle and then a 3-cycle low pulse on `key_0` (DEBOUNCE_CYCLES=4). Required: no `layer_start` activity.
- **Timeout.** Setup: TIMEOUT_CYCLES=50; layer 2 never answers. Required:
  - ERR entered exactly 50 cycles after `layer_start[2]`;
  - bytes 0x54, 0x0A;
  - `led_1` stays 1 until the next key press, then clears.
- **Backpressure and bad class.** Setup: `result_class`=12; `tx_ready` low for 5 cycles, then high. Required:
  - `tx_data`=0x45 held stable while `tx_valid` is high;
  - then 0x0A;
  - `led_1`=1.
- **Busy and spurious inputs.** Stimulus: a second key press mid-run, plus `layer_done[4]` asserted while `idx`=1. Required: both are ignored; exactly one result pair is sent.
- **Reset mid-run.** Stimulus: `rst`=1 for 1 cycle during WAIT on layer 3. Required:
  - next cycle: IDLE, `led_0`=0, `tx_valid`=0;
  - no further `layer_start` pulses.
